// File: rtl/parity_stream_unit.sv
// Pipelined even/odd parity generator and checker for a valid-qualified word stream,
// with per-frame parity accumulation and a saturating parity-error counter.
module parity_stream_unit #(
   parameter int unsigned WIDTH     = 8,
   parameter int unsigned FRAME_LEN = 4,
   parameter int unsigned CNT_W     = 8
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             in_valid,
   input  logic [WIDTH-1:0] in_data,
   input  logic             in_par,
   input  logic             odd_mode,
   input  logic             clr_cnt,
   output logic             out_valid,
   output logic [WIDTH-1:0] out_data,
   output logic             out_par,
   output logic             par_err,
   output logic             frame_done,
   output logic             frame_par,
   output logic [CNT_W-1:0] err_cnt,
   output logic             err_sticky
);

   localparam int unsigned IDX_W = $clog2(FRAME_LEN);
   localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(FRAME_LEN - 1);

   logic [IDX_W-1:0] idx;
   logic             acc;
   logic             word_x;
   logic             err_event;
   logic [CNT_W-1:0] cnt_next;
   logic             sticky_next;

   assign word_x    = ^in_data;
   assign err_event = out_valid & par_err;

   // Clear is applied before the increment, so a coincident error leaves a count of one.
   always_comb begin
      cnt_next    = clr_cnt ? '0 : err_cnt;
      sticky_next = clr_cnt ? 1'b0 : err_sticky;
      if (err_event) begin
         sticky_next = 1'b1;
         if (cnt_next != '1) begin
            cnt_next = cnt_next + CNT_W'(1);
         end
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         out_valid  <= 1'b0;
         out_data   <= '0;
         out_par    <= 1'b0;
         par_err    <= 1'b0;
         frame_done <= 1'b0;
         frame_par  <= 1'b0;
         idx        <= '0;
         acc        <= 1'b0;
      end else begin
         out_valid <= in_valid;
         if (in_valid) begin
            out_data <= in_data;
            out_par  <= word_x ^ odd_mode;
            par_err  <= word_x ^ in_par ^ odd_mode;
            if (idx == LAST_IDX) begin
               frame_done <= 1'b1;
               frame_par  <= acc ^ word_x ^ odd_mode;
               idx        <= '0;
               acc        <= 1'b0;
            end else begin
               frame_done <= 1'b0;
               idx        <= idx + IDX_W'(1);
               acc        <= acc ^ word_x;
            end
         end else begin
            out_par    <= 1'b0;
            par_err    <= 1'b0;
            frame_done <= 1'b0;
         end
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         err_cnt    <= '0;
         err_sticky <= 1'b0;
      end else begin
         err_cnt    <= cnt_next;
         err_sticky <= sticky_next;
      end
   end

endmodule

// File: tb/tb_parity_stream_unit.sv
// Directed and random stimulus for parity_stream_unit, checked against a
// queue-based scoreboard and a reference model of the frame and error-count state.
module tb_parity_stream_unit;

   localparam int unsigned WIDTH     = 8;
   localparam int unsigned FRAME_LEN = 4;
   localparam int unsigned CNT_W     = 2;
   localparam int CMAX = (1 << CNT_W) - 1;

   logic             clk = 1'b0;
   logic             rst;
   logic             in_valid;
   logic [WIDTH-1:0] in_data;
   logic             in_par;
   logic             odd_mode;
   logic             clr_cnt;
   logic             out_valid;
   logic [WIDTH-1:0] out_data;
   logic             out_par;
   logic             par_err;
   logic             frame_done;
   logic             frame_par;
   logic [CNT_W-1:0] err_cnt;
   logic             err_sticky;

   parity_stream_unit #(
      .WIDTH(WIDTH),
      .FRAME_LEN(FRAME_LEN),
      .CNT_W(CNT_W)
   ) dut (
      .clk(clk), .rst(rst), .in_valid(in_valid), .in_data(in_data), .in_par(in_par),
      .odd_mode(odd_mode), .clr_cnt(clr_cnt), .out_valid(out_valid), .out_data(out_data),
      .out_par(out_par), .par_err(par_err), .frame_done(frame_done), .frame_par(frame_par),
      .err_cnt(err_cnt), .err_sticky(err_sticky)
   );

   always #5 clk = ~clk;

   typedef struct packed {
      logic [WIDTH-1:0] d;
      logic             p;
      logic             e;
      logic             fd;
      logic             fp;
   } exp_t;

   exp_t q[$];

   int total = 0;
   int bad   = 0;

   int               m_idx    = 0;
   logic             m_acc    = 1'b0;
   logic             m_fp     = 1'b0;
   logic [WIDTH-1:0] m_data   = '0;
   int               m_cnt    = 0;
   logic             m_sticky = 1'b0;
   logic             m_pend   = 1'b0;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic model_reset();
      m_idx = 0; m_acc = 1'b0; m_fp = 1'b0; m_data = '0;
      m_cnt = 0; m_sticky = 1'b0; m_pend = 1'b0;
      q.delete();
   endtask

   task automatic chk_all_zero(input string tag);
      chk({tag, "_valid"}, 32'(out_valid), 0);
      chk({tag, "_data"}, 32'(out_data), 0);
      chk({tag, "_par"}, 32'(out_par), 0);
      chk({tag, "_err"}, 32'(par_err), 0);
      chk({tag, "_fd"}, 32'(frame_done), 0);
      chk({tag, "_fp"}, 32'(frame_par), 0);
      chk({tag, "_cnt"}, 32'(err_cnt), 0);
      chk({tag, "_sticky"}, 32'(err_sticky), 0);
   endtask

   // One clock: drive inputs, push the expected word, then compare after the edge.
   task automatic step(input logic v, input logic [WIDTH-1:0] d, input logic p,
                       input logic m, input logic c);
      exp_t e;
      exp_t got;
      logic x;
      e = '0;
      in_valid = v; in_data = d; in_par = p; odd_mode = m; clr_cnt = c;
      if (v) begin
         x    = ^d;
         e.d  = d;
         e.p  = x ^ m;
         e.e  = x ^ p ^ m;
         if (m_idx == FRAME_LEN - 1) begin
            e.fd  = 1'b1;
            e.fp  = m_acc ^ x ^ m;
            m_idx = 0;
            m_acc = 1'b0;
         end else begin
            e.fd  = 1'b0;
            e.fp  = m_fp;
            m_idx = m_idx + 1;
            m_acc = m_acc ^ x;
         end
         m_fp   = e.fp;
         m_data = d;
         q.push_back(e);
      end
      @(posedge clk);
      if (c) begin
         m_cnt    = 0;
         m_sticky = 1'b0;
      end
      if (m_pend) begin
         if (m_cnt != CMAX) m_cnt = m_cnt + 1;
         m_sticky = 1'b1;
      end
      m_pend = v & e.e;
      #1;
      chk("out_valid", 32'(out_valid), 32'(v));
      if (out_valid === 1'b1) begin
         if (q.size() == 0) begin
            chk("sb_nonempty", 0, 1);
         end else begin
            got = q.pop_front();
            chk("out_data", 32'(out_data), 32'(got.d));
            chk("out_par", 32'(out_par), 32'(got.p));
            chk("par_err", 32'(par_err), 32'(got.e));
            chk("frame_done", 32'(frame_done), 32'(got.fd));
            chk("frame_par", 32'(frame_par), 32'(got.fp));
         end
      end else begin
         chk("idle_par", 32'(out_par), 0);
         chk("idle_err", 32'(par_err), 0);
         chk("idle_fd", 32'(frame_done), 0);
         chk("idle_data_hold", 32'(out_data), 32'(m_data));
         chk("idle_fp_hold", 32'(frame_par), 32'(m_fp));
      end
      chk("err_cnt", 32'(err_cnt), 32'(m_cnt));
      chk("err_sticky", 32'(err_sticky), 32'(m_sticky));
   endtask

   task automatic pulse_reset(input string tag);
      #2 rst = 1'b1;
      #1 chk_all_zero(tag);
      #1 rst = 1'b0;
      model_reset();
   endtask

   initial begin
      logic [WIDTH-1:0] rd;
      logic             rp;
      logic             rm;
      rst = 1'b1; in_valid = 1'b0; in_data = '0; in_par = 1'b0;
      odd_mode = 1'b0; clr_cnt = 1'b0;
      @(posedge clk); @(posedge clk); #1;
      chk_all_zero("reset");
      @(negedge clk); rst = 1'b0;
      model_reset();

      // Word generation
      step(1'b1, 8'hA5, 1'b0, 1'b0, 1'b0);
      chk("a5_even_par", 32'(out_par), 0);
      step(1'b1, 8'hA5, 1'b1, 1'b1, 1'b0);
      chk("a5_odd_par", 32'(out_par), 1);
      step(1'b1, 8'h01, 1'b1, 1'b0, 1'b0);
      chk("01_even_par", 32'(out_par), 1);

      // Checking: erroring word, then a clean word in odd mode
      step(1'b1, 8'hA5, 1'b1, 1'b0, 1'b0);
      chk("a5_even_err", 32'(par_err), 1);
      step(1'b1, 8'hA5, 1'b1, 1'b1, 1'b0);
      chk("a5_odd_noerr", 32'(par_err), 0);
      chk("err_cnt_one", 32'(err_cnt), 1);
      chk("sticky_set", 32'(err_sticky), 1);
      step(1'b0, 8'h00, 1'b0, 1'b0, 1'b0);

      // Frame with an idle gap, even then odd last word
      pulse_reset("rst_frame");
      step(1'b1, 8'h01, 1'b1, 1'b0, 1'b0);
      step(1'b1, 8'h03, 1'b0, 1'b0, 1'b0);
      step(1'b1, 8'h07, 1'b1, 1'b0, 1'b0);
      chk("frame_no_early", 32'(frame_done), 0);
      step(1'b0, 8'h00, 1'b0, 1'b0, 1'b0);
      step(1'b1, 8'h00, 1'b0, 1'b0, 1'b0);
      chk("frame_even_done", 32'(frame_done), 1);
      chk("frame_even_par", 32'(frame_par), 0);
      step(1'b1, 8'h01, 1'b1, 1'b0, 1'b0);
      step(1'b1, 8'h03, 1'b0, 1'b0, 1'b0);
      step(1'b1, 8'h07, 1'b1, 1'b0, 1'b0);
      step(1'b1, 8'h00, 1'b1, 1'b1, 1'b0);
      chk("frame_odd_done", 32'(frame_done), 1);
      chk("frame_odd_par", 32'(frame_par), 1);
      step(1'b0, 8'h00, 1'b0, 1'b0, 1'b0);

      // Saturation, then clear coincident with a registered error
      step(1'b0, 8'h00, 1'b0, 1'b0, 1'b1);
      for (int i = 0; i < 5; i++) step(1'b1, 8'hA5, 1'b1, 1'b0, 1'b0);
      chk("sat_cnt4", 32'(err_cnt), 3);
      step(1'b1, 8'h01, 1'b0, 1'b0, 1'b0);
      chk("sat_cnt5", 32'(err_cnt), 3);
      step(1'b0, 8'h00, 1'b0, 1'b0, 1'b1);
      chk("clr_with_err", 32'(err_cnt), 1);
      chk("clr_with_err_sticky", 32'(err_sticky), 1);
      step(1'b0, 8'h00, 1'b0, 1'b0, 1'b1);
      chk("clr_plain", 32'(err_cnt), 0);

      // Reset mid-frame
      step(1'b1, 8'h11, 1'b0, 1'b0, 1'b0);
      step(1'b1, 8'h22, 1'b0, 1'b0, 1'b0);
      pulse_reset("rst_mid");
      step(1'b1, 8'h33, 1'b0, 1'b0, 1'b0);
      step(1'b1, 8'h44, 1'b0, 1'b0, 1'b0);
      chk("rst_mid_no_fd2", 32'(frame_done), 0);
      step(1'b1, 8'h55, 1'b0, 1'b0, 1'b0);
      step(1'b1, 8'h66, 1'b0, 1'b0, 1'b0);
      chk("rst_mid_fd4", 32'(frame_done), 1);

      // Back-to-back random words
      for (int k = 0; k < 8; k++) begin
         rd = WIDTH'($urandom);
         rp = 1'($urandom_range(1, 0));
         rm = 1'($urandom_range(1, 0));
         step(1'b1, rd, rp, rm, 1'b0);
         chk("rand_fd_pos", 32'(frame_done), 32'((k == 3) || (k == 7)));
      end
      step(1'b0, 8'h00, 1'b0, 1'b0, 1'b0);
      step(1'b0, 8'h00, 1'b0, 1'b0, 1'b0);
      chk("sb_drained", 32'(q.size()), 0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
